nn_mem_sys: RTL and testbench

// - On-chip bit memory for the binary NN accelerator: four 1-bit weight banks (W) and four 1-bit input banks (X).
// - Loaded serially from an external loader through one shared write-data bit; read back by the compute module.
// - W and X sides have independent address, bank-select and write-enable, so both can be accessed in the same cycle.
// - Sits between the top-level load/compute mux and the compute datapath.

---
 rtl/nn_mem_pkg.sv | 13 +
 rtl/nn_mem_bank.sv | 27 ++
 rtl/nn_mem_sys.sv | 41 ++++
 tb/tb_nn_mem_sys.sv | 119 +++++++++++
 4 files changed

// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg: shared sizes and bank-select decode for the NN bit memory
package nn_mem_pkg;
  localparam int W_ADDR_LEN = 20;
  localparam int X_ADDR_LEN = 10;
  localparam int W_SEL_LEN = 2;
  localparam int X_SEL_LEN = 2;
  localparam int unsigned W_DEPTH = 1024;
  localparam int unsigned X_DEPTH = 1024;
  localparam int NUM_BANKS = 4;
  function automatic logic [NUM_BANKS-1:0] bank_we(input logic we, input logic [1:0] sel);
    return {NUM_BANKS{we}} & (NUM_BANKS'(1) << sel);
  endfunction
endpackage

// File: rtl/nn_mem_bank.sv
// nn_mem_bank: 1-bit single-port RAM with sync write, registered read-first read and range check
module nn_mem_bank #(
  parameter int AW = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic          din_i,
  output logic          dout_o
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic mem_q [DEPTH];
  logic in_range;
  logic dout_d, dout_q;
  assign in_range = 32'(addr_i) < DEPTH;
  assign dout_d = in_range ? mem_q[addr_i[IW-1:0]] : 1'b0;
  assign dout_o = dout_q;
  // storage is never cleared; a write coinciding with reset is dropped
  always_ff @(posedge clk)
    if (rst && we_i && in_range) mem_q[addr_i[IW-1:0]] <= din_i;
  // read register samples the old contents, giving read-first behaviour
  always_ff @(posedge clk or negedge rst)
    if (!rst) dout_q <= 1'b0;
    else dout_q <= dout_d;
endmodule

// File: rtl/nn_mem_sys.sv
// nn_mem_sys: four weight and four input bit banks with independent W/X ports
module nn_mem_sys
  import nn_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_w,
  input  logic                  we_x,
  input  logic [W_ADDR_LEN-1:0] address_w,
  input  logic [X_ADDR_LEN-1:0] address_x,
  input  logic [W_SEL_LEN-1:0]  sel_w,
  input  logic [X_SEL_LEN-1:0]  sel_x,
  input  logic                  data_in,
  output logic                  data_out_w,
  output logic                  data_out_x
);
  logic [NUM_BANKS-1:0] we_w_v, we_x_v, dout_w, dout_x;
  logic [W_SEL_LEN-1:0] sel_w_q;
  logic [X_SEL_LEN-1:0] sel_x_q;
  assign we_w_v = bank_we(we_w, sel_w);
  assign we_x_v = bank_we(we_x, sel_x);
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    nn_mem_bank #(.AW(W_ADDR_LEN), .DEPTH(W_DEPTH)) u_w (
      .clk(clk), .rst(rst), .we_i(we_w_v[b]), .addr_i(address_w), .din_i(data_in), .dout_o(dout_w[b])
    );
    nn_mem_bank #(.AW(X_ADDR_LEN), .DEPTH(X_DEPTH)) u_x (
      .clk(clk), .rst(rst), .we_i(we_x_v[b]), .addr_i(address_x), .din_i(data_in), .dout_o(dout_x[b])
    );
  end
  // remember which bank was addressed so the output matches the read it belongs to
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sel_w_q <= '0;
      sel_x_q <= '0;
    end else begin
      sel_w_q <= sel_w;
      sel_x_q <= sel_x;
    end
  assign data_out_w = dout_w[sel_w_q];
  assign data_out_x = dout_x[sel_x_q];
endmodule

// File: tb/tb_nn_mem_sys.sv
// tb_nn_mem_sys: directed checks of load, readback, isolation, read-first, range and reset
module tb_nn_mem_sys;
  import nn_mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic we_w = 1'b0, we_x = 1'b0, data_in = 1'b0;
  logic [W_ADDR_LEN-1:0] address_w = '0;
  logic [X_ADDR_LEN-1:0] address_x = '0;
  logic [W_SEL_LEN-1:0] sel_w = '0;
  logic [X_SEL_LEN-1:0] sel_x = '0;
  logic data_out_w, data_out_x;
  int n_vec = 0, n_err = 0;
  logic [9:0] pat = 10'b11_0100_1101;
  logic [3:0] xpat = 4'b0110;

  nn_mem_sys dut (
    .clk(clk), .rst(rst), .we_w(we_w), .we_x(we_x), .address_w(address_w), .address_x(address_x),
    .sel_w(sel_w), .sel_x(sel_x), .data_in(data_in), .data_out_w(data_out_w), .data_out_x(data_out_x)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int s, input int a, input logic d);
    sel_w = W_SEL_LEN'(s); address_w = W_ADDR_LEN'(a); data_in = d; we_w = 1'b1;
    step();
    we_w = 1'b0;
  endtask

  task automatic wr_x(input int s, input int a, input logic d);
    sel_x = X_SEL_LEN'(s); address_x = X_ADDR_LEN'(a); data_in = d; we_x = 1'b1;
    step();
    we_x = 1'b0;
  endtask

  task automatic rd_w(input string tag, input int s, input int a, input logic exp);
    sel_w = W_SEL_LEN'(s); address_w = W_ADDR_LEN'(a); we_w = 1'b0;
    step();
    chk(tag, data_out_w, exp);
  endtask

  task automatic rd_x(input string tag, input int s, input int a, input logic exp);
    sel_x = X_SEL_LEN'(s); address_x = X_ADDR_LEN'(a); we_x = 1'b0;
    step();
    chk(tag, data_out_x, exp);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("reset_w", data_out_w, 1'b0);
    chk("reset_x", data_out_x, 1'b0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) wr_w(0, i, pat[i]);
    for (int i = 0; i < 10; i++) rd_w($sformatf("w_load_%0d", i), 0, i, pat[i]);
    for (int b = 0; b < 4; b++) wr_x(b, 5, xpat[b]);
    wr_w(1, 5, 1'b0);
    wr_w(2, 5, 1'b1);
    wr_w(3, 5, 1'b1);
    wr_w(0, 5, 1'b1);
    wr_w(3, 5, 1'b0);
    rd_w("iso_w0", 0, 5, 1'b1);
    rd_w("iso_w1", 1, 5, 1'b0);
    rd_w("iso_w2", 2, 5, 1'b1);
    rd_w("iso_w3", 3, 5, 1'b0);
    for (int b = 0; b < 4; b++) rd_x($sformatf("iso_x%0d", b), b, 5, xpat[b]);
    wr_x(2, 3, 1'b0);
    sel_w = 2'd0; address_w = 20'd7; sel_x = 2'd2; address_x = 10'd3; data_in = 1'b1;
    we_w = 1'b1; we_x = 1'b1;
    step();
    we_w = 1'b0; we_x = 1'b0;
    step();
    chk("sim_w", data_out_w, 1'b1);
    chk("sim_x", data_out_x, 1'b1);
    sel_w = 2'd0; address_w = 20'd1; data_in = 1'b1; we_w = 1'b1;
    step();
    chk("rf_w_old", data_out_w, 1'b0);
    we_w = 1'b0;
    step();
    chk("rf_w_new", data_out_w, 1'b1);
    wr_x(1, 9, 1'b0);
    sel_x = 2'd1; address_x = 10'd9; data_in = 1'b1; we_x = 1'b1;
    step();
    chk("rf_x_old", data_out_x, 1'b0);
    we_x = 1'b0;
    step();
    chk("rf_x_new", data_out_x, 1'b1);
    wr_w(0, int'(W_DEPTH), 1'b0);
    rd_w("oor_rd", 0, int'(W_DEPTH), 1'b0);
    rd_w("oor_alias", 0, 0, 1'b1);
    sel_x = 2'd2; address_x = 10'd3;
    rd_w("pre_rst", 0, 0, 1'b1);
    chk("pre_rst_x", data_out_x, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_w", data_out_w, 1'b0);
    chk("async_rst_x", data_out_x, 1'b0);
    sel_w = 2'd0; address_w = 20'd2; data_in = 1'b0; we_w = 1'b1;
    step();
    we_w = 1'b0;
    rst = 1'b1;
    rd_w("rst_drop_wr", 0, 2, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
